eth_fifo_dist_rd_ctrl: RTL

//  Pointer/read-side controller for the 16x32 distributed-RAM FIFO in the ethmac datapath.
//  - Generates the RAM write address from a push strobe.
//  - Drives the RAM read address and captures asynchronous read data into a first-word-fall-through output register.
//  - Presents words to the consumer with a valid/ready handshake; reports occupancy, full and overflow.

---
 rtl/eth_fifo_dist_rd_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/eth_fifo_dist_rd_ctrl.sv
// eth_fifo_dist_rd_ctrl: pointer and first-word-fall-through read controller for the ethmac 16x32 distributed-RAM FIFO.
// Define ETH_FIFO_RD_ALMOST_EN to build the registered almost_full flag.
module eth_fifo_dist_rd_ctrl #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned CNT_WIDTH     = 5,
    parameter int unsigned ALMOST_THRESH = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  write,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CNT_WIDTH-1:0]  ram_cnt,
    output logic                  full,
    output logic                  empty,
`ifdef ETH_FIFO_RD_ALMOST_EN
    output logic                  overflow,
    output logic                  almost_full
`else
    output logic                  overflow
`endif
);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  push;
    logic                  load;
    logic                  rd_valid_nxt;
    logic [CNT_WIDTH-1:0]  cnt_nxt;

    assign wr_addr     = wr_ptr;
    assign ram_rd_addr = rd_ptr;

    // full is the registered flag, so a load in the same cycle cannot admit a write
    assign push = write & ~full;
    assign load = (ram_cnt != '0) & (~rd_valid | rd_ready);

    always_comb begin
        cnt_nxt = ram_cnt;
        if (push & ~load)
            cnt_nxt = ram_cnt + 1'b1;
        else if (~push & load)
            cnt_nxt = ram_cnt - 1'b1;
    end

    always_comb begin
        rd_valid_nxt = rd_valid;
        if (load)
            rd_valid_nxt = 1'b1;
        else if (rd_valid & rd_ready)
            rd_valid_nxt = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (load) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= ram_rd_data;
            end
            rd_valid <= rd_valid_nxt;
            ram_cnt  <= cnt_nxt;
            full     <= (cnt_nxt == CNT_WIDTH'(DEPTH));
            empty    <= (cnt_nxt == '0) & ~rd_valid_nxt;
            if (write & full)
                overflow <= 1'b1;
        end
    end

`ifdef ETH_FIFO_RD_ALMOST_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            almost_full <= 1'b0;
        else if (clear)
            almost_full <= 1'b0;
        else
            almost_full <= (cnt_nxt >= CNT_WIDTH'(ALMOST_THRESH));
    end
`else
    logic unused_almost_thresh;
    assign unused_almost_thresh = ^ALMOST_THRESH;
`endif

endmodule
